// File: rtl/note_lane.sv
// Per-lane note scroller: shifts notes down a DEPTH-cell lane, exposes the two-cell hit zone,
// and turns the raw lane button into a key strobe. Optional macro NOTE_LANE_GHOST_EN adds ghost_out.
module note_lane #(
   parameter int DEPTH = 16,
   parameter int PER_W = 20
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic [PER_W-1:0] period,
   input  logic             spawn_in,
   input  logic             key_in,
   output logic [DEPTH-1:0] lane_out,
   output logic [1:0]       note_out,
   output logic             key_press,
   output logic             step_out,
   output logic             miss_out
`ifdef NOTE_LANE_GHOST_EN
   ,
   output logic             ghost_out
`endif
);

   logic [DEPTH-1:0] r_lane;
   logic [PER_W-1:0] r_cnt;
   logic             r_spawn;
   logic             r_sync1, r_sync2, r_sync3;
   logic             r_key_press;
   logic             r_step;
   logic             r_miss;
   logic             r_ghost;

   logic [PER_W-1:0] w_per_m1;
   logic             w_step;
   logic             w_hit;
   logic             w_hit_bot;
   logic             w_hit_good;
   logic [DEPTH-1:0] w_kept;
   logic [DEPTH-1:0] w_lane_nxt;

   // A period of 0 behaves as 1, so the terminal count never underflows.
   assign w_per_m1   = (period == '0) ? '0 : period - PER_W'(1);
   assign w_step     = enable & (r_cnt >= w_per_m1);
   assign w_hit      = r_key_press & enable;
   assign w_hit_bot  = w_hit & r_lane[DEPTH-1];
   assign w_hit_good = w_hit & ~r_lane[DEPTH-1] & r_lane[DEPTH-2];

   // The hit is removed before the shift, so a good-cell hit on a step vanishes at its new cell.
   always_comb begin
      w_kept = r_lane;
      if (w_hit_bot)
         w_kept[DEPTH-1] = 1'b0;
      if (w_hit_good)
         w_kept[DEPTH-2] = 1'b0;
      w_lane_nxt = w_kept;
      if (w_step)
         w_lane_nxt = {w_kept[DEPTH-2:0], r_spawn};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_lane      <= '0;
         r_cnt       <= '0;
         r_spawn     <= 1'b0;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync3     <= 1'b0;
         r_key_press <= 1'b0;
         r_step      <= 1'b0;
         r_miss      <= 1'b0;
         r_ghost     <= 1'b0;
      end else begin
         r_sync1     <= key_in;
         r_sync2     <= r_sync1;
         r_sync3     <= r_sync2;
         r_key_press <= r_sync2 & ~r_sync3;
         r_step      <= w_step;
         r_miss      <= w_step & w_kept[DEPTH-1];
         r_ghost     <= w_hit & ~r_lane[DEPTH-1] & ~r_lane[DEPTH-2];
         r_lane      <= w_lane_nxt;
         if (enable) begin
            r_cnt <= w_step ? '0 : r_cnt + PER_W'(1);
            // A spawn arriving on the step itself is kept for the following step.
            if (w_step)
               r_spawn <= spawn_in;
            else if (spawn_in)
               r_spawn <= 1'b1;
         end
      end
   end

   assign lane_out  = r_lane;
   assign note_out  = {r_lane[DEPTH-1], r_lane[DEPTH-2]};
   assign key_press = r_key_press;
   assign step_out  = r_step;
   assign miss_out  = r_miss;
`ifdef NOTE_LANE_GHOST_EN
   assign ghost_out = r_ghost;
`else
   logic w_unused_ghost;
   assign w_unused_ghost = r_ghost;
`endif

endmodule

// File: tb/tb_note_lane.sv
// Randomised bench for note_lane: a note-list model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares them against the lane.
module tb_note_lane;

   localparam int DEPTH = 16;
   localparam int PER_W = 20;
   localparam int EW    = DEPTH + 6;

   logic             clk;
   logic             resetn;
   logic             enable;
   logic [PER_W-1:0] period;
   logic             spawn_in;
   logic             key_in;
   logic [DEPTH-1:0] lane_out;
   logic [1:0]       note_out;
   logic             key_press;
   logic             step_out;
   logic             miss_out;
`ifdef NOTE_LANE_GHOST_EN
   logic             ghost_out;
`endif

   note_lane #(.DEPTH(DEPTH), .PER_W(PER_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .period    (period),
      .spawn_in  (spawn_in),
      .key_in    (key_in),
      .lane_out  (lane_out),
      .note_out  (note_out),
      .key_press (key_press),
      .step_out  (step_out),
      .miss_out  (miss_out)
`ifdef NOTE_LANE_GHOST_EN
      ,
      .ghost_out (ghost_out)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      else
         n_pass++;
   endtask

   // reference model: notes are a list of cell positions
   int m_notes[$];
   int m_new[$];
   bit m_pending;
   int m_phase;
   bit m_kp;
   bit kh[4];
   bit e_step, e_miss, e_ghost, found;
   int per;
   logic [DEPTH-1:0] e_lane;

   always @(posedge clk) begin
      e_step  = 1'b0;
      e_miss  = 1'b0;
      e_ghost = 1'b0;
      if (!resetn) begin
         m_notes.delete();
         m_pending = 1'b0;
         m_phase   = 0;
         m_kp      = 1'b0;
         for (int i = 0; i < 4; i++) kh[i] = 1'b0;
      end else begin
         if (m_kp && enable) begin
            found = 1'b0;
            for (int c = DEPTH - 1; c >= DEPTH - 2 && !found; c--)
               for (int j = 0; j < m_notes.size(); j++)
                  if (m_notes[j] == c && !found) begin
                     m_notes.delete(j);
                     found = 1'b1;
                  end
            e_ghost = !found;
         end
         per    = (period == 0) ? 1 : int'(period);
         e_step = enable && (m_phase >= per - 1);
         if (enable) m_phase = e_step ? 0 : m_phase + 1;
         if (e_step) begin
            m_new.delete();
            foreach (m_notes[j])
               if (m_notes[j] + 1 >= DEPTH) e_miss = 1'b1;
               else m_new.push_back(m_notes[j] + 1);
            if (m_pending) m_new.push_back(0);
            m_notes   = m_new;
            m_pending = spawn_in;
         end else if (enable && spawn_in) begin
            m_pending = 1'b1;
         end
         for (int i = 3; i > 0; i--) kh[i] = kh[i-1];
         kh[0] = key_in;
         m_kp  = kh[2] && !kh[3];
      end
      e_lane = '0;
      foreach (m_notes[j]) e_lane[m_notes[j]] = 1'b1;
      exp_q.push_back({e_ghost, e_miss, e_step, m_kp,
                       e_lane[DEPTH-1], e_lane[DEPTH-2], e_lane});
   end

   // monitor
   logic [EW-1:0] e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("lane_out", 32'(lane_out), 32'(e[DEPTH-1:0]));
         check("note_out", 32'(note_out), 32'(e[DEPTH+1:DEPTH]));
         check("key_press", 32'(key_press), 32'(e[DEPTH+2]));
         check("step_out", 32'(step_out), 32'(e[DEPTH+3]));
         check("miss_out", 32'(miss_out), 32'(e[DEPTH+4]));
`ifdef NOTE_LANE_GHOST_EN
         check("ghost_out", 32'(ghost_out), 32'(e[DEPTH+5]));
`endif
      end
   end

   // driver
   task automatic tick(input logic en, input logic sp, input logic key);
      @(posedge clk);
      #1;
      enable   = en;
      spawn_in = sp;
      key_in   = key;
   endtask

   int key_left;
   int en_off;

   initial begin
      resetn = 1'b0; enable = 1'b0; period = '0; spawn_in = 1'b0; key_in = 1'b0;
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      #0 resetn = 1'b1;
      period = 20'd4;
      // single note travels the whole lane and falls off
      tick(1'b1, 1'b1, 1'b0);
      repeat (80) tick(1'b1, 1'b0, 1'b0);
      // pause with spawn and key activity
      tick(1'b1, 1'b1, 1'b0);
      repeat (10) tick(1'b0, 1'b1, 1'b1);
      repeat (6) tick(1'b1, 1'b0, 1'b0);
      // shorten period mid-count
      period = 20'd8;
      repeat (6) tick(1'b1, 1'b0, 1'b0);
      period = 20'd2;
      repeat (6) tick(1'b1, 1'b0, 1'b0);
      // randomised play, occasional resets, period changes and pauses
      key_left = 0;
      en_off   = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 49) == 0) period = PER_W'($urandom_range(0, 6));
         if (en_off == 0 && $urandom_range(0, 99) == 0) en_off = $urandom_range(1, 12);
         if (key_left == 0) begin
            key_left = $urandom_range(1, 8);
            key_in   = ~key_in;
         end
         key_left--;
         resetn = ($urandom_range(0, 499) != 0);
         tick(en_off == 0, $urandom_range(0, 3) == 0, key_in);
         if (en_off > 0) en_off--;
      end
      resetn = 1'b0;
      tick(1'b1, 1'b0, 1'b0);
      resetn = 1'b1;
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/note_lane.md
Name: note_lane

Overview:
Per-lane note scroller, directly upstream of the per-lane scorer. It holds a DEPTH-cell shift register of notes that advances one cell per programmable step period. Its bottom two cells form the hit zone, driven out as the 2-bit note code the scorer consumes. It also synchronises and edge-detects the raw lane button into a 1-cycle key strobe, and removes notes that are hit or that fall off the lane.

Parameters:
DEPTH, 16, number of cells in the lane (min 3); cell 0 = top, cell DEPTH-1 = bottom
PER_W, 20, width of the step-period input

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
enable  in  1  run/pause; low freezes scrolling and spawning
period  in  PER_W  clk cycles per scroll step; 0 treated as 1
spawn_in  in  1  pulse: insert a note at cell 0 on the next step
key_in  in  1  raw asynchronous lane button, active-high
lane_out  out  DEPTH  cell occupancy for display, bit i = cell i
note_out  out  2  hit-zone code to scorer: [1]=perfect (cell DEPTH-1), [0]=good (cell DEPTH-2)
key_press  out  1  1-cycle strobe on synchronised rising edge of key_in
step_out  out  1  1-cycle pulse on each scroll step
miss_out  out  1  1-cycle pulse when an unhit note leaves cell DEPTH-1

Behaviour:
- Reset (resetn=0 at posedge): lane=0, tick counter=0, spawn latch=0, sync flops=0, key_press=0, step_out=0, miss_out=0. Reset mid-scroll discards all notes; no miss_out is generated for discarded notes.
- Reset always works: resetn=0 overrides enable and every other input.
- Tick counter:
  - enable=1: cnt increments each cycle.
  - Step condition: cnt >= max(period,1)-1. On a step cycle, cnt<=0 and step_out is registered high for 1 cycle.
  - Because of the >= compare, lowering period mid-count steps on the next cycle instead of wrapping.
  - enable=0: cnt holds and no steps occur.
- Spawn latch:
  - spawn_in=1 sets the latch (sticky, only while enable=1).
  - On a step, lane[0] <= latch and the latch clears.
  - spawn_in asserted on the step cycle itself is held for the following step.
  - Multiple spawns between steps collapse to one note.
- Shift on step: lane[i] <= lane[i-1] for i=1..DEPTH-1.
  - If old lane[DEPTH-1]=1 and it is not hit this cycle, miss_out=1 next cycle.
- Key path:
  - 2-flop synchroniser followed by a registered edge detect.
  - key_press goes high for exactly one cycle after the 3rd posedge following key_in going high.
  - Holding the key produces no further strobes.
  - Key path runs regardless of enable.
- note_out = {lane[DEPTH-1], lane[DEPTH-2]}, taken directly from the lane flops, so it changes only on clock edges.
  - The scorer samples note_out and key_press on the same edge that this block consumes the hit. The scorer therefore sees the pre-clear value.
- Hit consume (key_press=1 and enable=1):
  - If lane[DEPTH-1]=1, clear the bottom note.
  - Otherwise, if lane[DEPTH-2]=1, clear that note.
  - At most one note is cleared per press.
- Hit on a step cycle:
  - A bottom-cell hit suppresses miss_out; the note leaves anyway.
  - A good-cell hit clears the note at its new position, cell DEPTH-1, after the shift.
- key_press while enable=0: strobe is still output, but no note is cleared.

Optional Feature:
NOTE_LANE_GHOST_EN
- Defined: adds output ghost_out (1 bit). It is registered high for 1 cycle when key_press=1, enable=1 and both hit-zone cells are empty. It resets to 0.
- Undefined: port absent; empty-zone presses have no effect beyond key_press.

Test Plan:
1. Reset then period=4, enable=1, one spawn_in pulse (DEPTH=16) -> step_out every 4 cycles. Note reaches cell 15 after 16 steps; note_out=2'b10 during that step period; miss_out pulses once when it shifts out.
2. Note at cell 15 and key_in rises -> key_press pulses 3 edges later, note_out=2'b10 on that cycle. lane[15] clears on the same edge; no miss_out follows.
3. Note only at cell 14 and key press -> note_out=2'b01 at strobe, lane[14] cleared. A second note at cell 15 with both set -> only cell 15 cleared.
4. Key press coinciding with a step while the note is in cell 14 -> note appears cleared at cell 15 after the shift. With the note in cell 15 -> no miss_out.
5. enable=0 mid-run for 10 cycles with spawn_in pulsed -> lane and cnt frozen, spawn ignored, key_press still strobes. Then period changes 8->2 with cnt=5 -> step on the next cycle.
6. resetn=0 with notes in cells 13-15 -> next cycle lane_out=0, note_out=0, no miss_out. Ghost build: key press with empty zone -> ghost_out=1 for one cycle.
